// File: rtl/valve_chain_sequencer_if.sv
// valve_chain_sequencer_if: host handshake and valve-line bundle for valve_chain_sequencer
// master: drives start/stop/dwell/num_strokes/dir, observes air/busy/done/aborted/stroke_cnt
// slave:  the sequencer side of the same signals
interface valve_chain_sequencer_if #(
   parameter int DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic [DWELL_W-1:0] dwell;
   logic [15:0]        num_strokes;
   logic               dir;
   logic [3:0]         air;
   logic               busy;
   logic               done;
   logic               aborted;
   logic [15:0]        stroke_cnt;
   modport master (
      output start, stop, dwell, num_strokes, dir,
      input  air, busy, done, aborted, stroke_cnt
   );
   modport slave (
      input  start, stop, dwell, num_strokes, dir,
      output air, busy, done, aborted, stroke_cnt
   );
endinterface

// File: rtl/valve_chain_sequencer.sv
// valve_chain_sequencer: peristaltic stroke sequencer driving four pneumatic valve lines
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of valve_chain_sequencer_if (start/stop/dwell/num_strokes/dir in;
//            air/busy/done/aborted/stroke_cnt out, all registered)
// Macro VALVE_SEQ_REVERSE_EN enables dir=1 (valve3 -> valve0 strokes); otherwise dir is ignored.
module valve_chain_sequencer #(
   parameter int DWELL_W = 8,
   parameter int GAP     = 2
) (
   input logic                   clk,
   input logic                   rst,
   valve_chain_sequencer_if.slave bus
);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   typedef enum logic [1:0] {S_IDLE, S_STEP, S_GAP} state_t;
   state_t             state, state_n;
   logic [1:0]         step, step_n;
   logic [DWELL_W-1:0] cnt, cnt_n, d_q, d_n;
   logic [GW-1:0]      gcnt, gcnt_n;
   logic [15:0]        ns_q, ns_n, sc_q, sc_n;
   logic               rev_q, rev_n, rev_in;
   logic [3:0]         air_q, air_n;
   logic               busy_q, busy_n, done_q, done_n, ab_q, ab_n;
   logic               decide;
   logic [1:0]         first, nxt;
   logic               last;
   function automatic logic [3:0] pat(input logic [1:0] k);
      return ~(4'b0001 << k);
   endfunction
`ifdef VALVE_SEQ_REVERSE_EN
   assign rev_in = bus.dir;
`else
   assign rev_in = 1'b0;
`endif
   assign first = rev_q ? 2'd3 : 2'd0;
   assign nxt   = rev_q ? step - 2'd1 : step + 2'd1;
   assign last  = step == (rev_q ? 2'd0 : 2'd3);
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         step   <= '0;
         cnt    <= '0;
         gcnt   <= '0;
         d_q    <= DWELL_W'(1);
         ns_q   <= '0;
         rev_q  <= 1'b0;
         sc_q   <= '0;
         air_q  <= 4'hF;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ab_q   <= 1'b0;
      end else begin
         state  <= state_n;
         step   <= step_n;
         cnt    <= cnt_n;
         gcnt   <= gcnt_n;
         d_q    <= d_n;
         ns_q   <= ns_n;
         rev_q  <= rev_n;
         sc_q   <= sc_n;
         air_q  <= air_n;
         busy_q <= busy_n;
         done_q <= done_n;
         ab_q   <= ab_n;
      end
   end
   always_comb begin
      state_n = state;
      step_n  = step;
      cnt_n   = cnt;
      gcnt_n  = gcnt;
      d_n     = d_q;
      ns_n    = ns_q;
      rev_n   = rev_q;
      sc_n    = sc_q;
      air_n   = air_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
      ab_n    = ab_q;
      decide  = 1'b0;
      case (state)
         S_IDLE: begin
            air_n = 4'hF;
            if (bus.start && !bus.stop) begin
               d_n     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
               ns_n    = bus.num_strokes;
               rev_n   = rev_in;
               sc_n    = '0;
               step_n  = rev_in ? 2'd3 : 2'd0;
               cnt_n   = '0;
               air_n   = pat(rev_in ? 2'd3 : 2'd0);
               busy_n  = 1'b1;
               ab_n    = 1'b0;
               state_n = S_STEP;
            end
         end
         S_STEP: begin
            if (bus.stop) begin
               state_n = S_IDLE;
               air_n   = 4'hF;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               ab_n    = 1'b1;
            end else if (cnt == d_q - DWELL_W'(1)) begin
               if (last) begin
                  sc_n = sc_q + 16'd1;
                  if (GAP == 0) decide = 1'b1;
                  else begin
                     state_n = S_GAP;
                     gcnt_n  = '0;
                     air_n   = 4'hF;
                  end
               end else begin
                  step_n = nxt;
                  cnt_n  = '0;
                  air_n  = pat(nxt);
               end
            end else cnt_n = cnt + DWELL_W'(1);
         end
         S_GAP: begin
            if (bus.stop) begin
               state_n = S_IDLE;
               air_n   = 4'hF;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               ab_n    = 1'b1;
            end else if (gcnt == GW'(GAP - 1)) decide = 1'b1;
            else gcnt_n = gcnt + GW'(1);
         end
         default: state_n = S_IDLE;
      endcase
      // sc_n already includes the stroke that just finished
      if (decide) begin
         if (ns_q != '0 && sc_n == ns_q) begin
            state_n = S_IDLE;
            air_n   = 4'hF;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            ab_n    = 1'b0;
         end else begin
            state_n = S_STEP;
            step_n  = first;
            cnt_n   = '0;
            air_n   = pat(first);
         end
      end
   end
   assign bus.air        = air_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.aborted    = ab_q;
   assign bus.stroke_cnt = sc_q;
endmodule

// File: tb/tb_valve_chain_sequencer.sv
// tb_valve_chain_sequencer: checks GAP=0 and GAP=1 sequencers side by side against a stroke-timing model
module tb_valve_chain_sequencer;
   logic clk, rst;
   int   n_chk, n_fail;
   valve_chain_sequencer_if #(.DWELL_W(8)) b0 ();
   valve_chain_sequencer_if #(.DWELL_W(8)) b1 ();
   valve_chain_sequencer #(.DWELL_W(8), .GAP(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
   valve_chain_sequencer #(.DWELL_W(8), .GAP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic int pd(input int d);
      return (d == 0) ? 1 : d;
   endfunction
   function automatic logic [3:0] exp_air(input int d, input int g, input bit dr, input int i);
      int p, k;
      logic [3:0] one;
      one = 4'b0001;
      p = i % (4 * pd(d) + g);
      if (p >= 4 * pd(d)) return 4'hF;
      k = p / pd(d);
`ifdef VALVE_SEQ_REVERSE_EN
      if (dr) k = 3 - k;
`endif
      return ~(one << k);
   endfunction
   function automatic int exp_cnt(input int d, input int g, input int i);
      if (i < 4 * pd(d)) return 0;
      return (i - 4 * pd(d)) / (4 * pd(d) + g) + 1;
   endfunction
   task automatic set_in(input logic st, input logic sp, input int d, input int n, input logic dr);
      b0.start = st; b1.start = st;
      b0.stop = sp; b1.stop = sp;
      b0.dwell = 8'(d); b1.dwell = 8'(d);
      b0.num_strokes = 16'(n); b1.num_strokes = 16'(n);
      b0.dir = dr; b1.dir = dr;
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_air0"}, b0.air, 4'hF);
      chk({tag, "_busy0"}, b0.busy, 0);
      chk({tag, "_done0"}, b0.done, 0);
      chk({tag, "_air1"}, b1.air, 4'hF);
      chk({tag, "_busy1"}, b1.busy, 0);
      chk({tag, "_done1"}, b1.done, 0);
   endtask
   task automatic chk_dut(input int g, input int c, input int endc, input int d, input int n,
                          input bit dr, input bit stp, input logic [3:0] air, input logic busy,
                          input logic done, input logic ab, input logic [15:0] sc);
      int es;
      string t;
      t = $sformatf("g%0d_c%0d", g, c);
      es = stp ? exp_cnt(d, g, endc - 2) : n;
      if (c < endc) begin
         chk({t, "_air"}, air, exp_air(d, g, dr, c - 1));
         chk({t, "_busy"}, busy, 1);
         chk({t, "_done"}, done, 0);
         chk({t, "_cnt"}, sc, 32'(exp_cnt(d, g, c - 1)));
      end else begin
         chk({t, "_air"}, air, 4'hF);
         chk({t, "_busy"}, busy, 0);
         chk({t, "_done"}, done, (c == endc) ? 1 : 0);
         chk({t, "_cnt"}, sc, 32'(es & 16'hFFFF));
         if (c == endc) chk({t, "_aborted"}, ab, stp ? 1 : 0);
      end
   endtask
   // start at cycle 0; optional stop at cycle stop_at and ignored start pulse at ign_at
   task automatic run_case(input int d, input int n, input bit dr, input int stop_at, input int ign_at);
      int e0, e1, me;
      e0 = (stop_at >= 0) ? stop_at + 1 : 1 + n * (4 * pd(d));
      e1 = (stop_at >= 0) ? stop_at + 1 : 1 + n * (4 * pd(d) + 1);
      me = (e0 > e1) ? e0 : e1;
      set_in(1'b1, 1'b0, d, n, dr);
      for (int c = 1; c <= me; c++) begin
         @(posedge clk); #1;
         chk_dut(0, c, e0, d, n, dr, stop_at >= 0, b0.air, b0.busy, b0.done, b0.aborted, b0.stroke_cnt);
         chk_dut(1, c, e1, d, n, dr, stop_at >= 0, b1.air, b1.busy, b1.done, b1.aborted, b1.stroke_cnt);
         b0.start = (c == ign_at); b1.start = (c == ign_at);
         b0.stop = (c == stop_at); b1.stop = (c == stop_at);
      end
   endtask
   initial begin
      int d, n, me, sa, ia;
      bit dr;
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk_idle("reset_idle");
         chk("reset_cnt0", b0.stroke_cnt, 0);
         chk("reset_cnt1", b1.stroke_cnt, 0);
      end
      run_case(2, 1, 1'b0, -1, -1);
      run_case(0, 3, 1'b0, -1, -1);
      run_case(1, 0, 1'b0, 50, 20);
      run_case(1, 1, 1'b1, -1, -1);
      set_in(1'b1, 1'b1, 1, 1, 1'b0);
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, 1, 1, 1'b0);
      chk_idle("start_stop_idle");
      @(posedge clk); #1;
      chk_idle("start_stop_idle2");
      set_in(1'b0, 1'b1, 1, 1, 1'b0);
      @(posedge clk); #1;
      b0.stop = 1'b0; b1.stop = 1'b0;
      chk_idle("stop_in_idle");
      for (int r = 0; r < 8; r++) begin
         d = $urandom_range(0, 3);
         n = $urandom_range(1, 3);
         dr = 1'($urandom_range(0, 1));
         me = 1 + n * 4 * pd(d);
         sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, me - 1) : -1;
         ia = $urandom_range(1, (sa >= 0) ? sa : me - 1);
         run_case(d, n, dr, sa, ia);
      end
      set_in(1'b1, 1'b0, 1, 0, 1'b0);
      @(posedge clk); #1;
      b0.start = 1'b0; b1.start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_idle("rst_mid_run");
      chk("rst_cnt0", b0.stroke_cnt, 0);
      chk("rst_cnt1", b1.stroke_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_idle("after_rst");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
